// File: rtl/mem_pkg.sv
// Shared types and constants for the word-access memory responder.
//   mem_err_e   : response error code (OK, MISALIGN, RANGE)
//   rsp_state_e : responder FSM states
//   WORD_BYTES  : bytes per access word
package mem_pkg;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2
  } mem_err_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_e;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/mem_byte_array.sv
// Synchronous single-port byte storage with big-endian 32-bit word access.
//   clk, reset_n : clock; reset clears only the read-data register, never storage
//   wr_en        : write wdata as a big-endian word starting at byte addr
//   rd_en        : register the big-endian word starting at byte addr
//   rd_clr       : zero the read-data register (ignored when rd_en is set)
//   addr         : word-aligned byte index into storage
//   wdata        : write word, bits [31:24] land at addr
//   rdata        : registered read word
module mem_byte_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 72,
  parameter int unsigned IDX_W       = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [7:0]  mem [DEPTH_BYTES];
  logic [31:0] rd_word;
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        mem[addr + IDX_W'(i)] <= wdata[8*(WORD_BYTES-1-i) +: 8];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      rd_word[8*(WORD_BYTES-1-i) +: 8] = mem[addr + IDX_W'(i)];
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_word;
    end else if (rd_clr) begin
      rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder: one outstanding 32-bit word read/write per
// valid/ready request, answered on a valid/ready response channel after
// WAIT_STATES extra cycles. Storage is big-endian byte-addressed.
//   clk, reset_n          : clock, async active-low reset
//   req_valid/req_ready   : request handshake (accepted only in IDLE)
//   req_addr/we/wdata     : byte address, write flag, write word
//   rsp_valid/rsp_ready   : response handshake (held stable until taken)
//   rsp_rdata             : read word, zero for writes and errors
//   rsp_err               : 0 OK, 1 MISALIGN, 2 RANGE
module imem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 72,
  parameter int unsigned ADDR_W      = 64,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);
  localparam int unsigned CNT_W = 4;
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(DEPTH_BYTES - WORD_BYTES);

  rsp_state_e        state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic              we_d, we_q;
  logic [31:0]       wdata_d, wdata_q;
  mem_err_e          err_d, err_q;

  logic              commit;
  logic [ADDR_W-1:0] cur_addr;
  logic              cur_we;
  logic [31:0]       cur_wdata;
  mem_err_e          cur_err;
  logic              arr_wr_en, arr_rd_en, arr_rd_clr;

  // With no wait states the commit edge is also the accept edge, so the
  // transaction must be taken straight from the request bus.
  always_comb begin
    if (state_q == IDLE) begin
      cur_addr  = req_addr;
      cur_we    = req_we;
      cur_wdata = req_wdata;
    end else begin
      cur_addr  = addr_q;
      cur_we    = we_q;
      cur_wdata = wdata_q;
    end
  end

  always_comb begin
    if (cur_addr[1:0] != 2'b00) begin
      cur_err = ERR_MISALIGN;
    end else if (cur_addr > LAST_WORD) begin
      cur_err = ERR_RANGE;
    end else begin
      cur_err = ERR_OK;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    commit  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end else begin
            state_d = RESP;
            commit  = 1'b1;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      err_d = cur_err;
    end
  end

  assign arr_wr_en  = commit && cur_we && (cur_err == ERR_OK);
  assign arr_rd_en  = commit && !cur_we && (cur_err == ERR_OK);
  assign arr_rd_clr = commit && !arr_rd_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      err_q   <= ERR_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  mem_byte_array #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (arr_wr_en),
    .rd_en  (arr_rd_en),
    .rd_clr (arr_rd_clr),
    .addr   (cur_addr[IDX_W-1:0]),
    .wdata  (cur_wdata),
    .rdata  (rsp_rdata)
  );

  // Ready is forced low for the whole time reset is held.
  assign req_ready = reset_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int DEPTH = 72;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [63:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        v0 = 1'b0, v3 = 1'b0, rr0 = 1'b0, rr3 = 1'b0;
  logic        rdy0, rdy3, rv0, rv3;
  logic [31:0] rd0, rd3;
  logic [1:0]  er0, er3;

  int tests = 0;
  int fails = 0;

  logic [7:0] mdl [2][DEPTH];

  always #5 clk = ~clk;

  imem_responder #(.DEPTH_BYTES(72), .ADDR_W(64), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .req_valid(v0), .req_ready(rdy0),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_rdata(rd0), .rsp_err(er0));

  imem_responder #(.DEPTH_BYTES(72), .ADDR_W(64), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .req_valid(v3), .req_ready(rdy3),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rv3), .rsp_ready(rr3), .rsp_rdata(rd3), .rsp_err(er3));

  typedef struct {
    int          sel;
    logic        we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic [1:0]  exp_err;
  } vec_t;

  function automatic logic o_rdy(int sel); return sel == 0 ? rdy0 : rdy3; endfunction
  function automatic logic o_rv(int sel);  return sel == 0 ? rv0 : rv3;   endfunction
  function automatic logic [31:0] o_rd(int sel); return sel == 0 ? rd0 : rd3; endfunction
  function automatic logic [1:0]  o_er(int sel); return sel == 0 ? er0 : er3; endfunction

  task automatic set_valid(input int sel, input logic b);
    if (sel == 0) v0 = b; else v3 = b;
  endtask

  task automatic set_rready(input int sel, input logic b);
    if (sel == 0) rr0 = b; else rr3 = b;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: alignment first, then the word must lie entirely inside storage.
  task automatic model_txn(input int sel, input logic we, input logic [63:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] er);
    rd = '0;
    if (a % 4 != 0) er = 2'd1;
    else if (a >= 64'(DEPTH) || (64'(DEPTH) - a) < 4) er = 2'd2;
    else begin
      er = 2'd0;
      if (we) begin
        mdl[sel][int'(a)]     = wd[31:24];
        mdl[sel][int'(a) + 1] = wd[23:16];
        mdl[sel][int'(a) + 2] = wd[15:8];
        mdl[sel][int'(a) + 3] = wd[7:0];
      end else begin
        rd = {mdl[sel][int'(a)], mdl[sel][int'(a) + 1],
              mdl[sel][int'(a) + 2], mdl[sel][int'(a) + 3]};
      end
    end
  endtask

  task automatic txn(input int sel, input logic we, input logic [63:0] a, input logic [31:0] wd,
                     input int stall, output logic [31:0] rd, output logic [1:0] er);
    int lat;
    @(negedge clk);
    req_addr = a; req_we = we; req_wdata = wd;
    set_valid(sel, 1'b1);
    check("req_ready_idle", 64'(o_rdy(sel)), 64'd1);
    @(posedge clk); #1;
    set_valid(sel, 1'b0);
    req_addr = 64'($urandom); req_wdata = $urandom;
    lat = 1;
    while (!o_rv(sel) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 64'(lat), (sel == 0) ? 64'd1 : 64'd4);
    rd = o_rd(sel);
    er = o_er(sel);
    repeat (stall) @(posedge clk);
    @(negedge clk);
    set_rready(sel, 1'b1);
    @(posedge clk); #1;
    set_rready(sel, 1'b0);
    check("rsp_valid_drop", 64'(o_rv(sel)), 64'd0);
  endtask

  task automatic txn_check(input string name, input int sel, input logic we, input logic [63:0] a,
                           input logic [31:0] wd, input int stall);
    logic [31:0] rd, erd;
    logic [1:0]  er, eer;
    model_txn(sel, we, a, wd, erd, eer);
    txn(sel, we, a, wd, stall, rd, er);
    check({name, "_err"}, 64'(er), 64'(eer));
    check({name, "_rdata"}, 64'(rd), 64'(erd));
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] rd, exp_rd;
    logic [1:0]  er;

    vecs = '{
      '{0, 1'b1, 64'd0,            32'h00A00093, 32'h0,        2'd0},
      '{0, 1'b0, 64'd0,            32'h0,        32'h00A00093, 2'd0},
      '{0, 1'b1, 64'd2,            32'hFFFFFFFF, 32'h0,        2'd1},
      '{0, 1'b0, 64'd0,            32'h0,        32'h00A00093, 2'd0},
      '{0, 1'b0, 64'h1_0000_0000,  32'h0,        32'h0,        2'd2},
      '{1, 1'b1, 64'd0,            32'h00A00093, 32'h0,        2'd0},
      '{1, 1'b1, 64'd68,           32'h01408113, 32'h0,        2'd0},
      '{1, 1'b0, 64'd68,           32'h0,        32'h01408113, 2'd0},
      '{1, 1'b0, 64'd72,           32'h0,        32'h0,        2'd2},
      '{1, 1'b0, 64'd70,           32'h0,        32'h0,        2'd1},
      '{1, 1'b1, 64'h1_0000_0000,  32'h12345678, 32'h0,        2'd2},
      '{1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0, 32'h0,        2'd2},
      '{1, 1'b0, 64'd0,            32'h0,        32'h00A00093, 2'd0}
    };

    // reset state
    #12;
    check("ready_in_reset0", 64'(rdy0), 64'd0);
    check("ready_in_reset3", 64'(rdy3), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", 64'({rdy0, rdy3}), 64'd3);
    check("post_reset_valid", 64'({rv0, rv3}), 64'd0);
    check("post_reset_rdata", 64'({rd0, rd3}), 64'd0);
    check("post_reset_err",   64'({er0, er3}), 64'd0);

    // preload every word of both instances through the port
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < DEPTH; a += 4)
        txn_check("preload", s, 1'b1, 64'(a), $urandom, 0);

    // directed table
    foreach (vecs[i]) begin
      logic [31:0] mrd;
      logic [1:0]  mer;
      model_txn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, mrd, mer);
      txn(vecs[i].sel, vecs[i].we, vecs[i].addr, vecs[i].wdata, 0, rd, er);
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rd));
    end

    // backpressure with a competing request held on the bus
    @(negedge clk);
    req_addr = 64'd0; req_we = 1'b0; v0 = 1'b1;
    @(posedge clk); #1;
    req_addr = 64'd8; req_we = 1'b1; req_wdata = 32'h12345678;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid", 64'(rv0), 64'd1);
      check("bp_rdata", 64'(rd0), 64'h00A00093);
      check("bp_err",   64'(er0), 64'd0);
      check("bp_ready", 64'(rdy0), 64'd0);
    end
    @(negedge clk); rr0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; rr0 = 1'b0;
    check("bp_release_valid", 64'(rv0), 64'd0);
    check("bp_release_ready", 64'(rdy0), 64'd1);
    @(posedge clk); #1;
    check("bp_no_accept", 64'(rv0), 64'd0);
    txn_check("bp_addr8_untouched", 0, 1'b0, 64'd8, 32'h0, 0);

    // reset during WAIT drops an uncommitted write
    @(negedge clk);
    req_addr = 64'd4; req_we = 1'b1; req_wdata = 32'hDEADBEEF; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #2;
    check("rst_mid_valid", 64'({rv0, rv3}), 64'd0);
    check("rst_mid_ready", 64'(rdy3), 64'd0);
    @(negedge clk); @(negedge clk); reset_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      check("rst_no_rsp", 64'(rv3), 64'd0);
    end
    txn_check("rst_addr4_old", 1, 1'b0, 64'd4, 32'h0, 0);
    model_txn(1, 1'b0, 64'd0, 32'h0, exp_rd, er);
    check("rst_addr0_model", 64'(exp_rd), 64'h00A00093);
    txn_check("rst_addr0", 1, 1'b0, 64'd0, 32'h0, 0);

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      int          sel;
      logic [63:0] a;
      sel = int'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: a = 64'(4 * $urandom_range(0, 17));
        1: a = 64'($urandom_range(0, 75));
        2: a = {32'($urandom), 32'($urandom)};
        default: begin
          case ($urandom_range(0, 3))
            0: a = 64'd68;
            1: a = 64'd72;
            2: a = 64'hFFFF_FFFF_FFFF_FFFC;
            default: a = 64'h1_0000_0044;
          endcase
        end
      endcase
      txn_check("rand", sel, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
